shot_hit_detector: RTL

- Downstream consumer of the shot builder's shot position (position_x/position_y).
- Once per frame, snapshots the shot and the duck, tests their bounding boxes for overlap, and on a hit: pulses hit, requests shot removal, increments the score, then runs a flash interval during which no new hits are scored.
- Sits between the shot builder and the score/duck-control and display logic; runs on the same hcount/vcount raster.

---
 rtl/shot_hit_detector.sv | 136 +++++++++++++
 1 files changed

// File: rtl/shot_hit_detector.sv
// Per-frame shot/duck bounding-box hit detector. It snapshots both boxes on
// the frame tick, tests them for overlap, scores the hit and then runs a flash lockout.
module shot_hit_detector #(
  parameter int SHOT_W       = 4,
  parameter int SHOT_H       = 8,
  parameter int DUCK_W       = 32,
  parameter int DUCK_H       = 32,
  parameter int FRAME_LINE   = 480,
  parameter int FLASH_FRAMES = 30,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  input  logic [9:0]         shot_x,
  input  logic [9:0]         shot_y,
  input  logic               shot_active,
  input  logic [9:0]         duck_x,
  input  logic [9:0]         duck_y,
  input  logic               duck_alive,
  output logic               hit,
  output logic               shot_clear,
  output logic               flash,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state_dbg
);

  localparam int          CNT_W   = $clog2(FLASH_FRAMES + 1);
  localparam logic [9:0]  FRAME_V = 10'(FRAME_LINE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FLASH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic               tick_cond, tick_cond_q, tick;
  logic [9:0]         sx_q, sy_q, dx_q, dy_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hit_q, hit_d;
  logic               clr_q;
  logic               flash_q, flash_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               snap_en;
  logic               overlap;

  // Edge-detect the tick pixel so a stalled raster still yields one tick per frame.
  assign tick_cond = (hcount == 10'd0) && (vcount == FRAME_V);
  assign tick      = tick_cond && !tick_cond_q;

  // Sums are widened to 11 bits so boxes near the 1023 edge never wrap.
  always_comb begin
    logic [10:0] sx_e, sy_e, dx_e, dy_e;
    sx_e = {1'b0, sx_q};
    sy_e = {1'b0, sy_q};
    dx_e = {1'b0, dx_q};
    dy_e = {1'b0, dy_q};
    overlap = (sx_e < dx_e + 11'(DUCK_W)) &&
              (sx_e + 11'(SHOT_W) > dx_e) &&
              (sy_e < dy_e + 11'(DUCK_H)) &&
              (sy_e + 11'(SHOT_H) > dy_e);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick && shot_active && duck_alive) state_d = CHECK;
      CHECK:   state_d = overlap ? FLASH : IDLE;
      FLASH:   if (tick && (cnt_q == CNT_W'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; hit and shot_clear are single-cycle pulses
  // with no handshake: the consumer must act on the cycle they are high.
  always_comb begin
    snap_en = (state_q == IDLE) && (state_d == CHECK);
    hit_d   = (state_q == CHECK) && overlap;
    flash_d = flash_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    if (hit_d) begin
      flash_d = 1'b1;
      cnt_d   = CNT_W'(FLASH_FRAMES);
      if (score_q != {SCORE_W{1'b1}}) score_d = score_q + 1'b1;
    end else if ((state_q == FLASH) && tick) begin
      cnt_d = cnt_q - 1'b1;
      if (state_d == IDLE) flash_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cond_q <= 1'b0;
      sx_q        <= '0;
      sy_q        <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      cnt_q       <= '0;
      hit_q       <= 1'b0;
      clr_q       <= 1'b0;
      flash_q     <= 1'b0;
      score_q     <= '0;
    end else begin
      tick_cond_q <= tick_cond;
      if (snap_en) begin
        sx_q <= shot_x;
        sy_q <= shot_y;
        dx_q <= duck_x;
        dy_q <= duck_y;
      end
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      clr_q   <= hit_d;
      flash_q <= flash_d;
      score_q <= score_d;
    end
  end

  assign hit        = hit_q;
  assign shot_clear = clr_q;
  assign flash      = flash_q;
  assign score      = score_q;
  assign state_dbg  = state_q;

endmodule
